// File: rtl/riscv_cache_types_pkg.sv
// Request/response types shared by the cache request arbiter, its tracking FIFO
// and the round-robin pick helper.
package riscv_cache_types_pkg;

   localparam int CACHE_ID_W   = 4;
   localparam int CACHE_ADDR_W = 32;
   localparam int CACHE_DATA_W = 32;

   typedef struct packed {
      logic                    valid;
      logic [CACHE_ID_W-1:0]   id;
      logic [CACHE_ADDR_W-1:0] addr;
      logic                    we;
      logic [CACHE_DATA_W-1:0] wdata;
   } cache_req_t;

   typedef struct packed {
      logic                    valid;
      logic [CACHE_ID_W-1:0]   id;
      logic [CACHE_DATA_W-1:0] rdata;
      logic                    err;
   } cache_rsp_t;

   typedef struct packed {
      logic [CACHE_ID_W-1:0] req_idx;
      logic [CACHE_ID_W-1:0] orig_id;
   } arb_track_t;

   // First valid index at or after ptr, wrapping at num_req; returns ptr when none is valid.
   function automatic logic [CACHE_ID_W-1:0] rr_pick(
      input logic [15:0]           valid_vec,
      input logic [CACHE_ID_W-1:0] ptr,
      input int                    num_req
   );
      logic [CACHE_ID_W-1:0] pick;
      logic                  found;
      logic [4:0]            idx;
      pick  = ptr;
      found = 1'b0;
      for (int i = 0; i < 16; i++) begin
         idx = 5'(ptr) + 5'(i);
         if (idx >= 5'(num_req)) idx = idx - 5'(num_req);
         if (i < num_req && !found && valid_vec[idx[3:0]]) begin
            pick  = idx[CACHE_ID_W-1:0];
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/riscv_arb_track_fifo.sv
// In-order tracking FIFO holding {requester index, original id} for every
// request accepted by the arbiter until its response returns.
module riscv_arb_track_fifo
   import riscv_cache_types_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push,
   input  arb_track_t               push_data,
   input  logic                     pop,
   output arb_track_t               head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   arb_track_t     mem [DEPTH];
   logic [AW:0]    wr_q;
   logic [AW:0]    rd_q;
   logic           push_ok;
   logic           pop_ok;

   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (push_ok) wr_q <= wr_q + 1'b1;
         if (pop_ok)  rd_q <= rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem[wr_q[AW-1:0]] <= push_data;
   end

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign head  = mem[rd_q[AW-1:0]];
   assign count = wr_q - rd_q;
   assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign empty = (wr_q == rd_q);

endmodule

// File: rtl/riscv_cache_req_arbiter.sv
// Round-robin arbiter sharing one downstream cache request port between
// NUM_REQ requesters, with in-order response routing back to the originator.
module riscv_cache_req_arbiter
   import riscv_cache_types_pkg::*;
#(
   parameter int NUM_REQ         = 3,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  cache_req_t [NUM_REQ-1:0]            req_i,
   output logic       [NUM_REQ-1:0]            req_ready_o,
   output cache_rsp_t [NUM_REQ-1:0]            rsp_o,
   output cache_req_t                          cache_req_o,
   input  logic                                cache_req_ready_i,
   input  cache_rsp_t                          cache_rsp_i,
   output logic [$clog2(MAX_OUTSTANDING):0]    outstanding_o,
   output logic                                err_sticky_o
);

   logic [CACHE_ID_W-1:0] rr_ptr_q;
   cache_req_t            buf_q;
   logic                  err_q;

   logic [15:0]           valid_vec;
   logic [CACHE_ID_W-1:0] gnt;
   logic [CACHE_ID_W-1:0] rr_next;
   logic                  any_valid;
   logic                  can_accept;
   logic                  accept;
   cache_req_t            sel_req;
   cache_req_t            buf_d;
   arb_track_t            push_data;

   arb_track_t            fifo_head;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  rsp_hit;
   logic                  rsp_err;

   always_comb begin
      valid_vec = '0;
      for (int k = 0; k < NUM_REQ; k++) valid_vec[k] = req_i[k].valid;
   end

   assign gnt       = rr_pick(valid_vec, rr_ptr_q, NUM_REQ);
   assign any_valid = |valid_vec;

   // A pop in the same cycle never frees a slot: full always blocks acceptance.
   assign can_accept = (!buf_q.valid || cache_req_ready_i) && !fifo_full;
   assign accept     = any_valid && can_accept && !rst_i;
   assign rr_next    = (int'(gnt) == NUM_REQ - 1) ? '0 : gnt + 1'b1;

   always_comb begin
      sel_req     = '0;
      req_ready_o = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (gnt == CACHE_ID_W'(k)) begin
            sel_req        = req_i[k];
            req_ready_o[k] = accept;
         end
      end
      buf_d             = sel_req;
      buf_d.id          = gnt;
      push_data.req_idx = gnt;
      push_data.orig_id = sel_req.id;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_ptr_q <= '0;
         buf_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         if (accept) begin
            buf_q    <= buf_d;
            rr_ptr_q <= rr_next;
         end else if (cache_req_ready_i) begin
            buf_q    <= '0;
         end
         if (rsp_err) err_q <= 1'b1;
      end
   end

   riscv_arb_track_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_track_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .push      (accept),
      .push_data (push_data),
      .pop       (rsp_hit),
      .head      (fifo_head),
      .count     (outstanding_o),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign rsp_hit = cache_rsp_i.valid && !fifo_empty;
   assign rsp_err = cache_rsp_i.valid && (fifo_empty || (cache_rsp_i.id != fifo_head.req_idx));

   always_comb begin
      rsp_o = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (rsp_hit && fifo_head.req_idx == CACHE_ID_W'(k)) begin
            rsp_o[k]    = cache_rsp_i;
            rsp_o[k].id = fifo_head.orig_id;
         end
      end
   end

   assign cache_req_o  = buf_q;
   assign err_sticky_o = err_q;

endmodule

// File: tb/tb_riscv_cache_req_arbiter.sv
// Bench for riscv_cache_req_arbiter: vector table, directed corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_riscv_cache_req_arbiter;
   import riscv_cache_types_pkg::*;

   localparam int N    = 3;
   localparam int MAXO = 4;

   logic                  clk_i = 1'b0;
   logic                  rst_i;
   cache_req_t [N-1:0]    req_i;
   logic       [N-1:0]    req_ready_o;
   cache_rsp_t [N-1:0]    rsp_o;
   cache_req_t            cache_req_o;
   logic                  cache_req_ready_i;
   cache_rsp_t            cache_rsp_i;
   logic [2:0]            outstanding_o;
   logic                  err_sticky_o;

   riscv_cache_req_arbiter #(.NUM_REQ(N), .MAX_OUTSTANDING(MAXO)) dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .req_i             (req_i),
      .req_ready_o       (req_ready_o),
      .rsp_o             (rsp_o),
      .cache_req_o       (cache_req_o),
      .cache_req_ready_i (cache_req_ready_i),
      .cache_rsp_i       (cache_rsp_i),
      .outstanding_o     (outstanding_o),
      .err_sticky_o      (err_sticky_o)
   );

   always #5 clk_i = ~clk_i;

   int n_chk = 0;
   int n_err = 0;

   // reference model state
   int          m_ptr;
   cache_req_t  m_buf;
   arb_track_t  m_q[$];
   bit          m_err;
   int          m_last_g;
   int          m_issued;

   logic [3:0]  orig_ids [N] = '{4'hA, 4'h5, 4'h3};
   int          sched_cyc[$];
   logic [3:0]  sched_id[$];

   typedef struct {
      logic [2:0] vmask;
      logic       crdy;
      logic       rv;
      logic [3:0] rid;
      logic [2:0] e_ready;
      logic       e_cv;
      logic [3:0] e_cid;
      int         e_ridx;
      logic [3:0] e_rid;
      logic [2:0] e_out;
      logic       e_err;
   } vec_t;

   vec_t tbl[10];

   function automatic vec_t mkv(logic [2:0] vm, logic cr, logic rv, logic [3:0] rid,
                                logic [2:0] er, logic cv, logic [3:0] cid, int ridx,
                                logic [3:0] rrid, logic [2:0] eo, logic ee);
      vec_t v;
      v.vmask = vm; v.crdy = cr; v.rv = rv; v.rid = rid;
      v.e_ready = er; v.e_cv = cv; v.e_cid = cid; v.e_ridx = ridx;
      v.e_rid = rrid; v.e_out = eo; v.e_err = ee;
      return v;
   endfunction

   task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic set_req(int k, logic v);
      req_i[k].valid = v;
      req_i[k].id    = orig_ids[k];
      req_i[k].addr  = 32'h1000 + k;
      req_i[k].we    = (k % 2) == 1;
      req_i[k].wdata = 32'hCAFE_0000 + k;
   endtask

   function automatic int m_grant();
      for (int i = 0; i < N; i++) begin
         int k;
         k = (m_ptr + i) % N;
         if (req_i[k].valid) return k;
      end
      return -1;
   endfunction

   function automatic bit m_can();
      return (!m_buf.valid || cache_req_ready_i) && (m_q.size() < MAXO);
   endfunction

   task automatic check_model(string tag);
      int                 g;
      bit                 acc;
      logic [N-1:0]       er;
      cache_rsp_t [N-1:0] ers;
      g   = m_grant();
      acc = (g >= 0) && m_can();
      er  = '0;
      ers = '0;
      if (acc) er[g] = 1'b1;
      if (cache_rsp_i.valid && m_q.size() > 0) begin
         for (int k = 0; k < N; k++) begin
            if (int'(m_q[0].req_idx) == k) begin
               ers[k]    = cache_rsp_i;
               ers[k].id = m_q[0].orig_id;
            end
         end
      end
      chk({tag, ".ready"}, 128'(req_ready_o), 128'(er));
      chk({tag, ".creq"},  128'(cache_req_o), 128'(m_buf));
      chk({tag, ".rsp"},   128'(rsp_o), 128'(ers));
      chk({tag, ".outst"}, 128'(outstanding_o), 128'(m_q.size()));
      chk({tag, ".err"},   128'(err_sticky_o), 128'(m_err));
   endtask

   task automatic model_step();
      int         g;
      bit         acc;
      arb_track_t t;
      g   = m_grant();
      acc = (g >= 0) && m_can();
      m_last_g = acc ? g : -1;
      if (m_buf.valid && cache_req_ready_i) m_issued++;
      if (cache_rsp_i.valid) begin
         if (m_q.size() == 0) m_err = 1'b1;
         else begin
            if (cache_rsp_i.id != m_q[0].req_idx) m_err = 1'b1;
            void'(m_q.pop_front());
            if (m_issued > 0) m_issued--;
         end
      end
      if (acc) begin
         t.req_idx = 4'(g);
         t.orig_id = req_i[g].id;
         m_q.push_back(t);
         m_buf    = req_i[g];
         m_buf.id = 4'(g);
         m_ptr    = (g + 1) % N;
      end else if (cache_req_ready_i) begin
         m_buf = '0;
      end
   endtask

   task automatic cyc(string tag, bit do_chk);
      #1;
      if (do_chk) check_model(tag);
      @(posedge clk_i);
      model_step();
      @(negedge clk_i);
   endtask

   task automatic model_reset();
      m_ptr = 0; m_buf = '0; m_q.delete(); m_err = 1'b0; m_last_g = -1; m_issued = 0;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      req_i = '0;
      cache_req_ready_i = 1'b0;
      cache_rsp_i = '0;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      model_reset();
   endtask

   task automatic all_valid(logic v);
      for (int k = 0; k < N; k++) set_req(k, v);
   endtask

   initial begin
      cache_req_t         ec;
      cache_rsp_t [N-1:0] ers;

      tbl[0] = mkv(3'b100, 1, 0, 4'h0, 3'b100, 0, 4'h0, -1, 4'h0, 3'd0, 0);
      tbl[1] = mkv(3'b000, 1, 0, 4'h0, 3'b000, 1, 4'h2, -1, 4'h0, 3'd1, 0);
      tbl[2] = mkv(3'b111, 0, 1, 4'h2, 3'b001, 0, 4'h0,  2, 4'h3, 3'd1, 0);
      tbl[3] = mkv(3'b111, 0, 0, 4'h0, 3'b000, 1, 4'h0, -1, 4'h0, 3'd1, 0);
      tbl[4] = mkv(3'b111, 1, 0, 4'h0, 3'b010, 1, 4'h0, -1, 4'h0, 3'd1, 0);
      tbl[5] = mkv(3'b111, 1, 1, 4'h0, 3'b100, 1, 4'h1,  0, 4'hA, 3'd2, 0);
      tbl[6] = mkv(3'b000, 1, 1, 4'h0, 3'b000, 1, 4'h2,  1, 4'h5, 3'd2, 0);
      tbl[7] = mkv(3'b000, 0, 1, 4'h2, 3'b000, 0, 4'h0,  2, 4'h3, 3'd1, 1);
      tbl[8] = mkv(3'b000, 0, 1, 4'h0, 3'b000, 0, 4'h0, -1, 4'h0, 3'd0, 1);
      tbl[9] = mkv(3'b000, 0, 0, 4'h0, 3'b000, 0, 4'h0, -1, 4'h0, 3'd0, 1);

      // reset state
      do_reset();
      #1;
      chk("rst.outst", 128'(outstanding_o), 128'(0));
      chk("rst.cvalid", 128'(cache_req_o.valid), 128'(0));
      chk("rst.err", 128'(err_sticky_o), 128'(0));
      chk("rst.ready", 128'(req_ready_o), 128'(0));

      // vector table: lone requester 2 grant, round robin, stall, id mismatch, empty rsp
      for (int i = 0; i < 10; i++) begin
         for (int k = 0; k < N; k++) set_req(k, tbl[i].vmask[k]);
         cache_req_ready_i = tbl[i].crdy;
         cache_rsp_i       = '0;
         cache_rsp_i.valid = tbl[i].rv;
         cache_rsp_i.id    = tbl[i].rid;
         cache_rsp_i.rdata = 32'hD000_0000 + i;
         ec = '0;
         if (tbl[i].e_cv) begin
            ec.valid = 1'b1;
            ec.id    = tbl[i].e_cid;
            ec.addr  = 32'h1000 + 32'(tbl[i].e_cid);
            ec.we    = tbl[i].e_cid[0];
            ec.wdata = 32'hCAFE_0000 + 32'(tbl[i].e_cid);
         end
         ers = '0;
         for (int k = 0; k < N; k++) begin
            if (k == tbl[i].e_ridx) begin
               ers[k].valid = 1'b1;
               ers[k].id    = tbl[i].e_rid;
               ers[k].rdata = 32'hD000_0000 + i;
            end
         end
         #1;
         chk($sformatf("vec%0d.ready", i), 128'(req_ready_o), 128'(tbl[i].e_ready));
         chk($sformatf("vec%0d.creq", i), 128'(cache_req_o), 128'(ec));
         chk($sformatf("vec%0d.rsp", i), 128'(rsp_o), 128'(ers));
         chk($sformatf("vec%0d.outst", i), 128'(outstanding_o), 128'(tbl[i].e_out));
         chk($sformatf("vec%0d.err", i), 128'(err_sticky_o), 128'(tbl[i].e_err));
         cyc("", 0);
      end

      // continuous traffic, responses two cycles after each downstream handshake
      do_reset();
      all_valid(1'b1);
      cache_req_ready_i = 1'b1;
      sched_cyc.delete();
      sched_id.delete();
      for (int c = 0; c < 14; c++) begin
         cache_rsp_i = '0;
         if (sched_cyc.size() > 0 && sched_cyc[0] == c) begin
            cache_rsp_i.valid = 1'b1;
            cache_rsp_i.id    = sched_id[0];
            cache_rsp_i.rdata = 32'hBEEF_0000 + c;
            void'(sched_cyc.pop_front());
            void'(sched_id.pop_front());
         end
         if (m_buf.valid) begin
            sched_cyc.push_back(c + 2);
            sched_id.push_back(m_buf.id);
         end
         if (c >= 1 && c <= 6)
            chk($sformatf("rr_seq%0d", c), 128'(cache_req_o.id), 128'((c - 1) % 3));
         cyc("b2b", 1);
      end

      // downstream stall with requester 1 only
      do_reset();
      set_req(1, 1'b1);
      cache_req_ready_i = 1'b0;
      for (int c = 0; c < 6; c++) cyc("stall", 1);
      #1;
      chk("stall.outst", 128'(outstanding_o), 128'(1));
      chk("stall.cid", 128'(cache_req_o.id), 128'(1));
      chk("stall.ready", 128'(req_ready_o), 128'(0));
      cache_req_ready_i = 1'b1;
      cyc("stall_rel", 1);
      req_i = '0;
      cyc("stall_rel", 1);

      // tracking FIFO full; a response does not free a slot in its own cycle
      do_reset();
      all_valid(1'b1);
      cache_req_ready_i = 1'b1;
      for (int c = 0; c < 4; c++) cyc("fill", 1);
      #1;
      chk("full.outst", 128'(outstanding_o), 128'(4));
      chk("full.ready", 128'(req_ready_o), 128'(0));
      cyc("full", 1);
      cache_rsp_i = '0;
      cache_rsp_i.valid = 1'b1;
      cache_rsp_i.id    = 4'h0;
      #1;
      chk("full_pop.ready", 128'(req_ready_o), 128'(0));
      cyc("full_pop", 1);
      cache_rsp_i = '0;
      #1;
      chk("after_pop.ready", 128'(req_ready_o), 128'(3'b010));
      cyc("after_pop", 1);

      // asynchronous reset in the middle of traffic
      do_reset();
      all_valid(1'b1);
      cache_req_ready_i = 1'b1;
      for (int c = 0; c < 3; c++) cyc("pre_rst", 1);
      cache_req_ready_i = 1'b0;
      cache_rsp_i.valid = 1'b1;
      cache_rsp_i.id    = 4'h2;
      cyc("pre_rst", 1);
      cache_rsp_i = '0;
      cyc("pre_rst", 1);
      #2;
      rst_i = 1'b1;
      #1;
      chk("arst.outst", 128'(outstanding_o), 128'(0));
      chk("arst.cvalid", 128'(cache_req_o.valid), 128'(0));
      chk("arst.err", 128'(err_sticky_o), 128'(0));
      chk("arst.ready", 128'(req_ready_o), 128'(0));
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      model_reset();
      #1;
      chk("arst.first_gnt", 128'(req_ready_o), 128'(3'b001));
      cyc("post_rst", 1);
      cyc("post_rst", 1);

      // randomized traffic
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < N; k++) begin
            if (!req_i[k].valid || m_last_g == k) begin
               req_i[k].valid = ($urandom_range(0, 2) != 0);
               req_i[k].id    = 4'($urandom);
               req_i[k].addr  = $urandom;
               req_i[k].we    = 1'($urandom);
               req_i[k].wdata = $urandom;
            end
         end
         cache_req_ready_i = ($urandom_range(0, 3) != 0);
         cache_rsp_i = '0;
         if (m_issued > 0 && m_q.size() > 0 && $urandom_range(0, 1) == 1) begin
            cache_rsp_i.valid = 1'b1;
            cache_rsp_i.id    = m_q[0].req_idx;
            cache_rsp_i.rdata = $urandom;
            cache_rsp_i.err   = 1'($urandom);
         end
         cyc("rnd", 1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/riscv_cache_req_arbiter.md
Name: riscv_cache_req_arbiter

Overview:
Round-robin arbiter sharing one cache request port (L1 → L2, or L2 → L3) between NUM_REQ requesters, e.g. I-fetch, D-load/store and prefetch. Accepted requests are retagged with the requester index and held in a one-entry output buffer. Responses arrive in order and are routed back through an in-order tracking FIFO that restores each requester's original id. Sits between the L1 caches and the shared next-level cache.

Parameters:
NUM_REQ, 3, number of requesters; legal range 2..16 because the id field is 4 bits.
MAX_OUTSTANDING, 4, depth of the tracking FIFO; must be a power of 2, ≥2.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
req_i  in  NUM_REQ x cache_req_t  per-requester request; valid field = request valid
req_ready_o  out  NUM_REQ  per-requester accept
rsp_o  out  NUM_REQ x cache_rsp_t  per-requester response
cache_req_o  out  cache_req_t  shared downstream request
cache_req_ready_i  in  1  downstream accepts cache_req_o this cycle
cache_rsp_i  in  cache_rsp_t  downstream response, returned in request order
outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  tracking FIFO occupancy
err_sticky_o  out  1  sticky protocol error flag

Behaviour:
- Reset (async, rst_i=1): rr_ptr=0, output buffer empty (cache_req_o all zero), FIFO empty, outstanding_o=0, err_sticky_o=0, all req_ready_o=0.
- Grant, combinational:
  - Scan requesters with req_i[k].valid, starting at rr_ptr and wrapping modulo NUM_REQ; the first found is the grantee g.
  - req_ready_o[g]=1 only when can_accept is true; all other req_ready_o are 0.
- can_accept = (buffer empty OR cache_req_ready_i) AND (FIFO count < MAX_OUTSTANDING).
  - A FIFO pop in the same cycle does NOT free a slot; full blocks acceptance regardless of a simultaneous pop.
- On accept (req_i[g].valid && req_ready_o[g]):
  - Buffer loads req_i[g] with id replaced by g, zero-extended to 4 bits.
  - FIFO pushes {g, original id}.
  - rr_ptr <= (g+1) mod NUM_REQ.
  - Latency from accept to cache_req_o.valid is 1 cycle.
- rr_ptr updates only on accept; an idle cycle leaves it unchanged.
- Output buffer:
  - cache_req_o.valid stays high and the payload stays stable until cache_req_ready_i.
  - Handshake and refill in the same cycle are allowed, giving back-to-back throughput of 1 request/cycle.
  - With no refill, the buffer empties and cache_req_o becomes all zero.
- Response path, combinational, 0 latency:
  - When cache_rsp_i.valid and the FIFO is non-empty, with head = {h, oid}: rsp_o[h] = cache_rsp_i with id = oid, and the FIFO pops.
  - All other rsp_o are all zero.
- Id check: if cache_rsp_i.id != h, the response is still routed to h and err_sticky_o <= 1.
- Response while the FIFO is empty: dropped, no rsp_o asserted, err_sticky_o <= 1.
- err_sticky_o clears only on reset.
- outstanding_o = FIFO count.
  - It includes the request held in the buffer, because the push happens at accept.
  - It changes by +1, -1, or 0 when a push and a pop occur in the same cycle.
- Pointer arithmetic: FIFO read/write pointers are $clog2(MAX_OUTSTANDING)+1 bits and wrap naturally; full = MSBs differ and LSBs are equal.
- Requester rules:
  - A requester must hold valid and payload until it sees ready.
  - Requesters do not wait for ready before asserting valid.

Decomposition:
- riscv_cache_types_pkg gains:
  - localparam CACHE_ID_W=4.
  - typedef arb_track_t {logic [CACHE_ID_W-1:0] req_idx; logic [CACHE_ID_W-1:0] orig_id;}.
  - Function rr_pick(valid_vec, ptr) returning the grant index.
- One sub-module: riscv_arb_track_fifo (parameterised depth, arb_track_t entries, push/pop/count, async active-high reset). The output buffer and grant logic stay in the top module.

Test Plan:
1. Reset mid-traffic: 2 outstanding plus a buffered request, then assert rst_i → outstanding_o=0, cache_req_o.valid=0, err_sticky_o=0, rr_ptr=0 (next grant goes to requester 0 when all are valid).
2. All 3 requesters valid continuously, cache_req_ready_i=1, responses returned 2 cycles later → cache_req_o.id sequence is 0,1,2,0,1,2; one request per cycle; each rsp_o[k] carries its original id (e.g. 4'hA, 4'h5, 4'h3).
3. Only requester 2 valid, with rr_ptr=0 → granted immediately; rr_ptr becomes 0 after the accept.
4. cache_req_ready_i=0 for 5 cycles while requester 1 is valid → cache_req_o stays stable; req_ready_o[1] becomes 0 after the first accept; no second push.
5. MAX_OUTSTANDING=4, no responses → 4 accepts, then outstanding_o=4 and all req_ready_o=0. A response arriving in the same cycle as a pending request → no accept that cycle, accept the next cycle.
6. Response with id 1 when the FIFO head is h=0 → routed to rsp_o[0] and err_sticky_o=1. Response while the FIFO is empty → all rsp_o invalid, err_sticky_o stays 1.
